// File: rtl/ula_arbiter_pkg.sv
// Shared definitions for the ULA arbiter, the ULA and its clients.
// Holds FSM state encodings, requester ids and default widths.
package ula_arbiter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_OPW   = 3;

  // Latency counter width, wide enough for LAT-1 with LAT up to 4
  localparam int CNT_W = 2;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ula_arbiter_rr_arb2.sv
// Two-way request arbiter for the shared ULA.
// Ports: req_a/req_b requests, last = id served last;
//   win_id = chosen id (valid when any), any = some request.
// ULA_ARB_PRIO_EN: A always wins ties, last is ignored;
//   otherwise round-robin against last.
module ula_arbiter_rr_arb2
  import ula_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic win_id,
  output logic any
);

  assign any = req_a | req_b;

`ifdef ULA_ARB_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win_id = ID_A;
    if (!req_a && req_b)
      win_id = ID_B;
  end
`else
  always_comb begin
    win_id = ID_A;
    if (req_a && req_b)
      win_id = ~last;
    else if (req_b)
      win_id = ID_B;
  end
`endif

endmodule

// File: rtl/ula_arbiter.sv
// Shares one ULA between requesters A and B: arbitrate, latch
// the winner's operands, launch, wait LAT cycles, return result.
// Ports: clk, rst (async, active high); req/opa/opb/op per
//   requester; gnt_a/gnt_b grant pulses; alu_a/alu_b/alu_op/
//   alu_start toward the ULA; alu_res from the ULA; res,
//   res_valid, res_id, done_a/done_b toward the requesters.
// ULA_ARB_PRIO_EN: fixed priority (A wins ties), no pointer.
module ula_arbiter
  import ula_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] opa_a,
  input  logic [WIDTH-1:0] opb_a,
  input  logic [OPW-1:0]   op_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] opa_b,
  input  logic [WIDTH-1:0] opb_b,
  input  logic [OPW-1:0]   op_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_id,
  output logic             done_a,
  output logic             done_b
);

  if (LAT < 1 || LAT > 4) begin : g_lat_bad
    $error("ula_arbiter: LAT must be in 1..4");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             id;
  logic             win_id;
  logic             any;
  logic             arb_last;

`ifdef ULA_ARB_PRIO_EN
  assign arb_last = ID_B;
`else
  logic last;
  assign arb_last = last;
`endif

  ula_arbiter_rr_arb2 u_arb (
    .req_a  (req_a),
    .req_b  (req_b),
    .last   (arb_last),
    .win_id (win_id),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      id        <= ID_A;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
`ifndef ULA_ARB_PRIO_EN
      last      <= ID_B;
`endif
    end else begin
      // Pulses default low; each is set for exactly one state
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      alu_start <= 1'b0;
      res_valid <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any) begin
            id <= win_id;
            if (win_id == ID_B) begin
              alu_a  <= opa_b;
              alu_b  <= opb_b;
              alu_op <= op_b;
            end else begin
              alu_a  <= opa_a;
              alu_b  <= opb_a;
              alu_op <= op_a;
            end
            // Registered here so they are high during ISSUE
            alu_start <= 1'b1;
            gnt_a     <= (win_id == ID_A);
            gnt_b     <= (win_id == ID_B);
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CNT_W'(LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            res       <= alu_res;
            res_valid <= 1'b1;
            res_id    <= id;
            done_a    <= (id == ID_A);
            done_b    <= (id == ID_B);
            state     <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
`ifndef ULA_ARB_PRIO_EN
          last <= id;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
